// File: rtl/io_mmio_ctrl.sv
// MMIO controller for the 0x8000_0000 IO region: cycle/instruction counters,
// UART RX/TX handshakes and TX holding register, with 1-cycle registered reads.
module io_mmio_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_mem_we,
    input  logic             i_mem_re,
    input  logic             i_instr_retire,
    input  logic [7:0]       i_uart_rx_data_out,
    input  logic             i_uart_rx_data_out_valid,
    output logic             o_uart_rx_data_out_ready,
    output logic [7:0]       o_uart_tx_data_in,
    output logic             o_uart_tx_data_in_valid,
    input  logic             i_uart_tx_data_in_ready,
    output logic             o_uart_rx_valid,
    output logic             o_uart_tx_ready,
    output logic [7:0]       o_uart_rx_out,
    output logic [WIDTH-1:0] o_cyc_ctr,
    output logic [WIDTH-1:0] o_instr_ctr
);

    localparam logic [2:0] OFF_CTRL  = 3'd0;
    localparam logic [2:0] OFF_RX    = 3'd1;
    localparam logic [2:0] OFF_TX    = 3'd2;
    localparam logic [2:0] OFF_CYC   = 3'd4;
    localparam logic [2:0] OFF_INSTR = 3'd5;
    localparam logic [2:0] OFF_CRST  = 3'd6;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_FULL = 1'b1
    } tx_state_t;

    tx_state_t        r_tx_state;
    tx_state_t        w_tx_state_nxt;
    logic             w_tx_load;
    logic [7:0]       r_tx_data;
    logic [WIDTH-1:0] r_cyc_cnt;
    logic [WIDTH-1:0] r_instr_cnt;

    logic             w_io;
    logic [2:0]       w_off;
    logic             w_wr_tx;
    logic             w_wr_crst;
    logic             w_rd_cap;
    logic             w_tx_status;

    assign w_io      = (i_addr[WIDTH-1:WIDTH-2] == 2'b10);
    assign w_off     = i_addr[4:2];
    assign w_wr_tx   = i_mem_we && w_io && (w_off == OFF_TX);
    assign w_wr_crst = i_mem_we && w_io && (w_off == OFF_CRST);

    // Unmapped and write-only offsets leave the read registers untouched.
    assign w_rd_cap  = i_mem_re && w_io &&
                       ((w_off == OFF_CTRL) || (w_off == OFF_RX) ||
                        (w_off == OFF_CYC)  || (w_off == OFF_INSTR));

    assign o_uart_rx_data_out_ready = i_mem_re && w_io && (w_off == OFF_RX) &&
                                      i_uart_rx_data_out_valid;

    assign w_tx_status             = (r_tx_state == TX_IDLE) && i_uart_tx_data_in_ready;
    assign o_uart_tx_data_in_valid = (r_tx_state == TX_FULL);
    assign o_uart_tx_data_in       = r_tx_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cyc_cnt   <= '0;
            r_instr_cnt <= '0;
        end else if (w_wr_crst) begin
            r_cyc_cnt   <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + WIDTH'(1);
            if (i_instr_retire) begin
                r_instr_cnt <= r_instr_cnt + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_cyc_ctr       <= '0;
            o_instr_ctr     <= '0;
            o_uart_rx_valid <= 1'b0;
            o_uart_tx_ready <= 1'b0;
            o_uart_rx_out   <= 8'h00;
        end else if (w_rd_cap) begin
            o_cyc_ctr       <= r_cyc_cnt;
            o_instr_ctr     <= r_instr_cnt;
            o_uart_rx_valid <= i_uart_rx_data_out_valid;
            o_uart_tx_ready <= w_tx_status;
            o_uart_rx_out   <= i_uart_rx_data_out;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            if (w_tx_load) begin
                r_tx_data <= i_wdata[7:0];
            end
        end
    end

    // A store that arrives while FULL, even on the accept cycle, is dropped.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_load      = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_wr_tx) begin
                    w_tx_state_nxt = TX_FULL;
                    w_tx_load      = 1'b1;
                end
            end
            TX_FULL: begin
                if (i_uart_tx_data_in_ready) begin
                    w_tx_state_nxt = TX_IDLE;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Directed bench for io_mmio_ctrl: counters, clear, RX/TX handshakes, wrap and
// reset during a pending transmit, all against hand-computed values.
module tb_io_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_we;
    logic        mem_re;
    logic        instr_retire;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic        rx_data_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic        rx_valid;
    logic        tx_ready;
    logic [7:0]  rx_out;
    logic [31:0] cyc_ctr;
    logic [31:0] instr_ctr;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    io_mmio_ctrl #(.WIDTH(32)) dut (
        .i_clk                    (clk),
        .i_rst                    (rst),
        .i_addr                   (addr),
        .i_wdata                  (wdata),
        .i_mem_we                 (mem_we),
        .i_mem_re                 (mem_re),
        .i_instr_retire           (instr_retire),
        .i_uart_rx_data_out       (rx_data),
        .i_uart_rx_data_out_valid (rx_data_valid),
        .o_uart_rx_data_out_ready (rx_data_ready),
        .o_uart_tx_data_in        (tx_data),
        .o_uart_tx_data_in_valid  (tx_data_valid),
        .i_uart_tx_data_in_ready  (tx_data_ready),
        .o_uart_rx_valid          (rx_valid),
        .o_uart_tx_ready          (tx_ready),
        .o_uart_rx_out            (rx_out),
        .o_cyc_ctr                (cyc_ctr),
        .o_instr_ctr              (instr_ctr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [31:0] a);
        mem_re = 1'b1;
        addr   = a;
        @(negedge clk);
        mem_re = 1'b0;
        addr   = 32'h0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_we = 1'b1;
        addr   = a;
        wdata  = d;
        @(negedge clk);
        mem_we = 1'b0;
        addr   = 32'h0;
        wdata  = 32'h0;
    endtask

    initial begin
        rst           = 1'b1;
        addr          = 32'h0;
        wdata         = 32'h0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        instr_retire  = 1'b0;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        tx_data_ready = 1'b0;
        step(3);

        chk("rst_tx_valid", {31'b0, tx_data_valid}, 32'd0);
        chk("rst_tx_data",  {24'b0, tx_data},       32'd0);
        chk("rst_cyc",      cyc_ctr,                32'd0);
        chk("rst_instr",    instr_ctr,              32'd0);
        chk("rst_rx_out",   {24'b0, rx_out},        32'd0);
        chk("rst_status",   {30'b0, rx_valid, tx_ready}, 32'd0);

        // 100 non-reset edges, then the load edge captures 100
        rst = 1'b0;
        step(100);
        load(32'h8000_0010);
        chk("cyc_100", cyc_ctr, 32'd100);

        instr_retire = 1'b1;
        step(7);
        instr_retire = 1'b0;
        load(32'h8000_0014);
        chk("instr_7", instr_ctr, 32'd7);

        store(32'h8000_0018, 32'h0);
        instr_retire = 1'b1;
        step(3);
        instr_retire = 1'b0;
        load(32'h8000_0014);
        chk("instr_after_clr", instr_ctr, 32'd3);
        chk("cyc_after_clr",   cyc_ctr,   32'd3);

        // clear wins over a simultaneous retire
        instr_retire = 1'b1;
        store(32'h8000_0018, 32'h0);
        instr_retire = 1'b0;
        load(32'h8000_0014);
        chk("clr_beats_inc_instr", instr_ctr, 32'd0);
        chk("clr_beats_inc_cyc",   cyc_ctr,   32'd0);

        rx_data_valid = 1'b1;
        rx_data       = 8'h5A;
        mem_re        = 1'b1;
        addr          = 32'h8000_0004;
        #1;
        chk("rx_ready_pulse", {31'b0, rx_data_ready}, 32'd1);
        @(negedge clk);
        mem_re = 1'b0;
        addr   = 32'h0;
        #1;
        chk("rx_ready_drop", {31'b0, rx_data_ready}, 32'd0);
        chk("rx_byte",       {24'b0, rx_out},        32'h5A);
        chk("rx_valid_cap",  {31'b0, rx_valid},      32'd1);

        rx_data_valid = 1'b0;
        rx_data       = 8'h33;
        mem_re        = 1'b1;
        addr          = 32'h8000_0004;
        #1;
        chk("rx_no_ready_when_empty", {31'b0, rx_data_ready}, 32'd0);
        @(negedge clk);
        mem_re = 1'b0;
        addr   = 32'h0;
        chk("rx_stale_byte",  {24'b0, rx_out},   32'h33);
        chk("rx_valid_empty", {31'b0, rx_valid}, 32'd0);

        rx_data_valid = 1'b1;
        rx_data       = 8'h77;
        mem_re        = 1'b1;
        addr          = 32'h0000_0004;
        #1;
        chk("non_io_no_ready", {31'b0, rx_data_ready}, 32'd0);
        @(negedge clk);
        mem_re = 1'b0;
        addr   = 32'h0;
        chk("non_io_hold", {24'b0, rx_out}, 32'h33);
        load(32'h8000_000C);
        chk("unmapped_hold", {24'b0, rx_out}, 32'h33);

        tx_data_ready = 1'b1;
        load(32'h8000_0000);
        chk("ctrl_rx_tx", {30'b0, rx_valid, tx_ready}, 32'd3);
        rx_data_valid = 1'b0;

        tx_data_ready = 1'b0;
        store(32'h8000_0008, 32'h0000_0141);
        chk("tx_valid_set", {31'b0, tx_data_valid}, 32'd1);
        chk("tx_data_41",   {24'b0, tx_data},       32'h41);
        step(5);
        chk("tx_valid_held", {31'b0, tx_data_valid}, 32'd1);
        chk("tx_data_held",  {24'b0, tx_data},       32'h41);
        load(32'h8000_0000);
        chk("ctrl_tx_busy", {30'b0, rx_valid, tx_ready}, 32'd0);
        store(32'h8000_0008, 32'h42);
        chk("tx_drop_42", {24'b0, tx_data}, 32'h41);

        tx_data_ready = 1'b1;
        mem_we        = 1'b1;
        addr          = 32'h8000_0008;
        wdata         = 32'h43;
        #1;
        chk("tx_valid_on_accept", {31'b0, tx_data_valid}, 32'd1);
        @(negedge clk);
        mem_we = 1'b0;
        addr   = 32'h0;
        wdata  = 32'h0;
        chk("tx_idle_after_accept", {31'b0, tx_data_valid}, 32'd0);
        chk("tx_drop_43",           {24'b0, tx_data},       32'h41);
        load(32'h8000_0000);
        chk("ctrl_tx_ready", {30'b0, rx_valid, tx_ready}, 32'd1);

        store(32'h8000_0008, 32'h55);
        chk("tx_data_55", {24'b0, tx_data}, 32'h55);
        step(1);
        chk("tx_55_accepted", {31'b0, tx_data_valid}, 32'd0);

        force dut.r_cyc_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_cyc_cnt;
        mem_re = 1'b1;
        addr   = 32'h8000_0010;
        @(negedge clk);
        chk("cyc_max", cyc_ctr, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("cyc_wrap", cyc_ctr, 32'h0);
        mem_re = 1'b0;
        addr   = 32'h0;

        tx_data_ready = 1'b0;
        store(32'h8000_0008, 32'h99);
        chk("tx_full_pre_rst", {31'b0, tx_data_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx_valid", {31'b0, tx_data_valid}, 32'd0);
        chk("rst_mid_tx_data",  {24'b0, tx_data},       32'd0);
        chk("rst_mid_cyc_out",  cyc_ctr,                32'd0);
        rst = 1'b0;
        load(32'h8000_0010);
        chk("rst_mid_cyc_cnt", cyc_ctr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
